// File: rtl/err_uart_streamer_pkg.sv
// Shared constants for the error-sample UART streamer: sync byte, frame size, FSM states.
package err_uart_streamer_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Payload byte that follows the byte numbered idx (0: after sync -> MSB, 1: after MSB -> LSB).
  function automatic logic [7:0] frame_byte(input logic [15:0] sample, input logic [1:0] idx);
    return (idx == 2'd0) ? sample[15:8] : sample[7:0];
  endfunction

endpackage

// File: rtl/err_uart_streamer_sync_fifo.sv
// Sample FIFO: push dropped when full, registered read on pop, level kept as its own counter.
// One-cycle read latency; full is judged on the pre-pop level.
module err_uart_streamer_sync_fifo #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wr_dat_i,
  output logic [W-1:0]  rd_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int          DEPTH      = 2 ** AW;
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [W-1:0]  rd_dat_q;
  logic          push_ok, pop_ok;

  assign full_o   = (level_q == LEVEL_FULL);
  assign empty_o  = (level_q == '0);
  assign push_ok  = push_i && !full_o;
  assign pop_ok   = pop_i && !empty_o;
  assign rd_dat_o = rd_dat_q;
  assign level_o  = level_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rd_dat_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_dat_q <= mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/err_uart_streamer.sv
// Streams buffered error samples as A5/MSB/LSB 8N1 frames; o_tx is registered (one cycle behind the FSM).
// No backpressure upstream: samples arriving at a full FIFO are dropped and flagged in o_overflow.
module err_uart_streamer
  import err_uart_streamer_pkg::*;
#(
  parameter int NB_DATA      = 16,
  parameter int NB_FIFO_ADDR = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NB_DATA-1:0]      i_err,
  input  logic                    i_valid,
  output logic                    o_tx,
  output logic                    o_busy,
  output logic                    o_overflow,
  output logic [NB_FIFO_ADDR:0]   o_fifo_level
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(FRAME_BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, ovf_q;
  logic               pop, fifo_full, fifo_empty, baud_tick;
  logic [NB_DATA-1:0] head;
  logic [15:0]        shadow;

  err_uart_streamer_sync_fifo #(
    .W  (NB_DATA),
    .AW (NB_FIFO_ADDR)
  ) u_fifo (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .push_i   (i_valid),
    .pop_i    (pop),
    .wr_dat_i (i_err),
    .rd_dat_o (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (o_fifo_level)
  );

  // The FIFO read register holds the popped sample for the whole frame, so it acts as the shadow.
  assign shadow    = 16'($signed(head));
  assign baud_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != IDLE);
      if (i_valid && fifo_full) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = baud_tick ? '0 : cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          byte_idx_d = 2'd0;
          shift_d    = SYNC_BYTE;
          state_d    = START;
        end
      end
      START: begin
        if (baud_tick) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = IDLE;
          end else begin
            shift_d    = frame_byte(shadow, byte_idx_q);
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_err_uart_streamer.sv
// Bench for err_uart_streamer: two instances (16-bit and 12-bit samples), mid-bit UART decoders, byte scoreboards.
module tb_err_uart_streamer;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] err16 = '0;
  logic        vld16 = 1'b0;
  logic [11:0] err12 = '0;
  logic        vld12 = 1'b0;
  logic        tx16, busy16, ovf16, tx12, busy12, ovf12;
  logic [AW:0] lvl16, lvl12;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp16[$], exp12[$], rx16[$], rx12[$];
  int         rxt16[$];

  err_uart_streamer #(.NB_DATA(16), .NB_FIFO_ADDR(AW), .CLKS_PER_BIT(CPB)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_err(err16), .i_valid(vld16),
    .o_tx(tx16), .o_busy(busy16), .o_overflow(ovf16), .o_fifo_level(lvl16)
  );

  err_uart_streamer #(.NB_DATA(12), .NB_FIFO_ADDR(AW), .CLKS_PER_BIT(CPB)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_err(err12), .i_valid(vld12),
    .o_tx(tx12), .o_busy(busy12), .o_overflow(ovf12), .o_fifo_level(lvl12)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic line(input int w);
    return (w == 0) ? tx16 : tx12;
  endfunction

  task automatic wait_neg(input int n, inout bit ok);
    repeat (n) begin
      @(negedge clk);
      if (rst) ok = 1'b0;
    end
  endtask

  // Decoder: start bit seen at a falling clock edge, then every bit sampled near its middle.
  task automatic mon_line(input int w);
    logic [7:0] b;
    bit ok;
    int t0;
    forever begin
      @(negedge clk);
      if (!rst && line(w) == 1'b0) begin
        t0 = cyc;
        ok = 1'b1;
        b  = '0;
        wait_neg(CPB / 2, ok);
        if (line(w) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          wait_neg(CPB, ok);
          b[i] = line(w);
        end
        wait_neg(CPB, ok);
        if (line(w) !== 1'b1) ok = 1'b0;
        if (ok) begin
          if (w == 0) begin
            rx16.push_back(b);
            rxt16.push_back(t0);
          end else begin
            rx12.push_back(b);
          end
        end
      end
    end
  endtask

  initial mon_line(0);
  initial mon_line(1);

  task automatic wait_rx(input int w, input int n, input int budget, output int got);
    int k;
    k = 0;
    got = (w == 0) ? rx16.size() : rx12.size();
    while (got < n && k < budget) begin
      @(negedge clk);
      k++;
      got = (w == 0) ? rx16.size() : rx12.size();
    end
  endtask

  // Called at a falling edge; the sample is taken on the following rising edge.
  task automatic drive16(input logic [15:0] v, input bit keep);
    err16 = v;
    vld16 = 1'b1;
    if (keep) begin
      exp16.push_back(8'hA5);
      exp16.push_back(v[15:8]);
      exp16.push_back(v[7:0]);
    end
    @(negedge clk);
    vld16 = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    rx16.delete(); rxt16.delete(); rx12.delete();
    exp16.delete(); exp12.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (tx16 !== 1'b1 || busy16 !== 1'b0 || lvl16 !== '0 || ovf16 !== 1'b0) begin
        n_err++;
        $display("FAIL reset16 cyc%0d: tx=%b busy=%b lvl=%0d ovf=%b, required 1 0 0 0", i, tx16, busy16, lvl16, ovf16);
      end
      n_vec++;
      if (tx12 !== 1'b1 || busy12 !== 1'b0 || lvl12 !== '0 || ovf12 !== 1'b0) begin
        n_err++;
        $display("FAIL reset12 cyc%0d: tx=%b busy=%b lvl=%0d ovf=%b, required 1 0 0 0", i, tx12, busy12, lvl12, ovf12);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int first_low, busy_cnt, got;
    logic [7:0] a, e;
    drive16(16'h8001, 1'b1);
    n_vec++;
    if (lvl16 !== 3'd1 || busy16 !== 1'b0) begin
      n_err++;
      $display("FAIL single_push: lvl=%0d busy=%b, required 1 0", lvl16, busy16);
    end
    first_low = -1;
    busy_cnt  = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy16 === 1'b1) busy_cnt++;
      if (tx16 === 1'b0 && first_low < 0) first_low = k;
    end
    n_vec++;
    if (first_low != 2) begin
      n_err++;
      $display("FAIL single_tx_latency: first low %0d cycles after push, required 2", first_low);
    end
    n_vec++;
    if (busy_cnt != 30 * CPB) begin
      n_err++;
      $display("FAIL single_busy_len: %0d cycles, required %0d", busy_cnt, 30 * CPB);
    end
    n_vec++;
    if (lvl16 !== '0) begin
      n_err++;
      $display("FAIL single_level_end: %0d, required 0", lvl16);
    end
    wait_rx(0, 3, 100, got);
    n_vec++;
    if (got < 3) begin
      n_err++;
      $display("FAIL single_rx_count: %0d bytes, required 3", got);
    end
    for (int i = 0; i < 3 && rx16.size() > 0 && exp16.size() > 0; i++) begin
      a = rx16.pop_front();
      e = exp16.pop_front();
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL single_byte%0d: got %h, required %h", i, a, e);
      end
    end
    rxt16.delete();
  endtask

  task automatic test_signext();
    logic [11:0] v;
    logic [15:0] s;
    logic [7:0] a, e;
    int got;
    v = 12'hF80;
    s = {{4{v[11]}}, v};
    exp12.push_back(8'hA5);
    exp12.push_back(s[15:8]);
    exp12.push_back(s[7:0]);
    @(negedge clk);
    err12 = v;
    vld12 = 1'b1;
    @(negedge clk);
    vld12 = 1'b0;
    wait_rx(1, 3, 300, got);
    n_vec++;
    if (got < 3) begin
      n_err++;
      $display("FAIL signext_rx_count: %0d bytes, required 3", got);
    end
    for (int i = 0; i < 3 && rx12.size() > 0 && exp12.size() > 0; i++) begin
      a = rx12.pop_front();
      e = exp12.pop_front();
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL signext_byte%0d: got %h, required %h", i, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, e;
    int got, want;
    reset_dut();
    for (int i = 1; i <= 6; i++) drive16(16'(i), i <= 5);
    n_vec++;
    if (lvl16 !== 3'd4 || ovf16 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_fill: lvl=%0d ovf=%b, required 4 1", lvl16, ovf16);
    end
    wait_rx(0, 15, 800, got);
    n_vec++;
    if (got < 15) begin
      n_err++;
      $display("FAIL b2b_rx_count: %0d bytes, required 15", got);
    end
    for (int j = 1; j < rxt16.size(); j++) begin
      want = (j % 3 == 0) ? 30 * CPB + 1 - 20 * CPB : 10 * CPB;
      n_vec++;
      if (rxt16[j] - rxt16[j-1] != want) begin
        n_err++;
        $display("FAIL b2b_gap%0d: %0d cycles between byte starts, required %0d", j, rxt16[j] - rxt16[j-1], want);
      end
    end
    for (int i = 0; i < 15 && rx16.size() > 0 && exp16.size() > 0; i++) begin
      a = rx16.pop_front();
      e = exp16.pop_front();
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL b2b_byte%0d: got %h, required %h", i, a, e);
      end
    end
    n_vec++;
    if (ovf16 !== 1'b1 || lvl16 !== '0) begin
      n_err++;
      $display("FAIL b2b_end: ovf=%b lvl=%0d, required 1 0", ovf16, lvl16);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] a, e;
    int got, max_lvl;
    bit saw_ovf;
    reset_dut();
    max_lvl = 0;
    saw_ovf = 1'b0;
    for (int s = 0; s < 50; s++) begin
      drive16(16'($urandom), 1'b1);
      repeat (30 * CPB) begin
        @(negedge clk);
        if (int'(lvl16) > max_lvl) max_lvl = int'(lvl16);
        if (ovf16 !== 1'b0) saw_ovf = 1'b1;
      end
    end
    n_vec++;
    if (max_lvl > 1) begin
      n_err++;
      $display("FAIL periodic_level: max %0d, required <= 1", max_lvl);
    end
    n_vec++;
    if (saw_ovf) begin
      n_err++;
      $display("FAIL periodic_overflow: overflow seen, required none");
    end
    wait_rx(0, 150, 600, got);
    n_vec++;
    if (got < 150) begin
      n_err++;
      $display("FAIL periodic_rx_count: %0d bytes, required 150", got);
    end
    for (int i = 0; i < 150 && rx16.size() > 0 && exp16.size() > 0; i++) begin
      a = rx16.pop_front();
      e = exp16.pop_front();
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL periodic_byte%0d: got %h, required %h", i, a, e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] a, e;
    int got;
    reset_dut();
    for (int i = 0; i < 6; i++) drive16(16'h5A00 + 16'(i), 1'b0);
    // First push landed 5.5 cycles ago; MSB byte data bit 3 spans edges N+57..N+60.
    repeat (53) @(negedge clk);
    n_vec++;
    if (busy16 !== 1'b1 || lvl16 !== 3'd4 || ovf16 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pre: busy=%b lvl=%0d ovf=%b, required 1 4 1", busy16, lvl16, ovf16);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (tx16 !== 1'b1 || busy16 !== 1'b0 || lvl16 !== '0 || ovf16 !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reset: tx=%b busy=%b lvl=%0d ovf=%b, required 1 0 0 0", tx16, busy16, lvl16, ovf16);
    end
    rst = 1'b0;
    repeat (50) @(negedge clk);
    rx16.delete(); rxt16.delete(); exp16.delete();
    drive16(16'h1234, 1'b1);
    wait_rx(0, 3, 300, got);
    n_vec++;
    if (got < 3) begin
      n_err++;
      $display("FAIL abort_rx_count: %0d bytes, required 3", got);
    end
    for (int i = 0; i < 3 && rx16.size() > 0 && exp16.size() > 0; i++) begin
      a = rx16.pop_front();
      e = exp16.pop_front();
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL abort_byte%0d: got %h, required %h", i, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signext();
    test_back_to_back();
    test_periodic();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
